// File: rtl/line_burst_adapter.sv
// Line-to-burst adapter: turns one LINE_W-bit cache line read/write into a
// sequence of BURST_W-bit memory beats and returns a single completion pulse.
module line_burst_adapter #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    if ((LINE_W % BURST_W) != 0) begin : g_bad_width
        $error("LINE_W must be an exact multiple of BURST_W");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [LINE_W-1:0] r_line;

    // Byte offset within a line never reaches memory; fold it away on purpose.
    logic w_unused_offset;
    assign w_unused_offset = ^address_i[OFF_W-1:0];

    function automatic logic [BURST_W-1:0] beat_of(input logic [LINE_W-1:0] line,
                                                    input logic [CNT_W-1:0]  idx);
        beat_of = line[BURST_W*int'(idx) +: BURST_W];
    endfunction

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_count   <= {CNT_W{1'b0}};
            r_line    <= {LINE_W{1'b0}};
            line_o    <= {LINE_W{1'b0}};
            burst_o   <= {BURST_W{1'b0}};
            address_o <= 32'h0000_0000;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            resp_o    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    resp_o <= 1'b0;
                    if (write_i) begin
                        r_line    <= line_i;
                        address_o <= {address_i[31:OFF_W], {OFF_W{1'b0}}};
                        r_count   <= {CNT_W{1'b0}};
                        burst_o   <= line_i[BURST_W-1:0];
                        write_o   <= 1'b1;
                        r_state   <= WR_BURST;
                    end else if (read_i) begin
                        address_o <= {address_i[31:OFF_W], {OFF_W{1'b0}}};
                        r_count   <= {CNT_W{1'b0}};
                        read_o    <= 1'b1;
                        r_state   <= RD_BURST;
                    end else begin
                        r_state   <= IDLE;
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        line_o[BURST_W*int'(r_count) +: BURST_W] <= burst_i;
                        if (r_count == LAST_BEAT) begin
                            r_count <= {CNT_W{1'b0}};
                            read_o  <= 1'b0;
                            resp_o  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_count <= r_count + CNT_ONE;
                        end
                    end
                end
                WR_BURST: begin
                    if (resp_i) begin
                        if (r_count == LAST_BEAT) begin
                            r_count <= {CNT_W{1'b0}};
                            write_o <= 1'b0;
                            burst_o <= {BURST_W{1'b0}};
                            resp_o  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            // Present the next beat as soon as the current one is taken.
                            r_count <= r_count + CNT_ONE;
                            burst_o <= beat_of(r_line, r_count + CNT_ONE);
                        end
                    end
                end
                DONE: begin
                    resp_o  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_count <= {CNT_W{1'b0}};
                    read_o  <= 1'b0;
                    write_o <= 1'b0;
                    resp_o  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_burst_adapter.sv
// Self-checking bench for line_burst_adapter: directed scenarios plus random
// transactions checked against a line/beat reference model.
module tb_line_burst_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i, line_o;
    logic [31:0]  address_i, address_o;
    logic         read_i, write_i, resp_o;
    logic [63:0]  burst_i, burst_o;
    logic         read_o, write_o, resp_i;

    line_burst_adapter #(.LINE_W(256), .BURST_W(64)) dut (
        .clk(clk), .rst(rst),
        .line_i(line_i), .line_o(line_o),
        .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
        .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
        .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus for the memory side and observations from the cache side.
    logic [63:0]  beats [4];
    int           gaps  [4];
    int           cyc, obs_first_resp, obs_resp_cnt, basic_lat;
    bit           obs_req_ok, obs_hold_ok, obs_saw_read, obs_saw_write;
    logic         obs_req_after;
    logic [63:0]  obs_beats [4];
    logic [31:0]  obs_addr;
    logic [255:0] last_read_line;
    logic [354:0] all_outs;

    // Reference model: the line is the beats in arrival order, lowest word first.
    function automatic logic [255:0] model_line();
        logic [255:0] r;
        for (int i = 0; i < 4; i++) r[64*i +: 64] = beats[i];
        return r;
    endfunction

    function automatic int model_latency();
        int s = 0;
        for (int i = 0; i < 4; i++) s += gaps[i];
        return 1 + 4 + s;
    endfunction

    function automatic logic [31:0] model_addr(input logic [31:0] a);
        return a - (a % 32);
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic rand_beats(input int max_gap);
        for (int i = 0; i < 4; i++) begin
            beats[i] = {$urandom, $urandom};
            gaps[i]  = $urandom_range(0, max_gap);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (resp_o === 1'b1) begin
            obs_resp_cnt++;
            if (obs_first_resp < 0) obs_first_resp = cyc;
        end
        if (read_o === 1'b1) obs_saw_read = 1'b1;
        if (write_o === 1'b1) obs_saw_write = 1'b1;
    endtask

    // Cache + memory driver: issues one request and plays the memory side.
    task automatic drive_txn(input bit wr, input bit both, input logic [31:0] addr,
                             input logic [255:0] wline);
        cyc = 0; obs_first_resp = -1; obs_resp_cnt = 0;
        obs_req_ok = 1'b1; obs_hold_ok = 1'b1; obs_saw_read = 1'b0; obs_saw_write = 1'b0;
        address_i = addr; line_i = wline;
        write_i = wr; read_i = !wr || both;
        tick();
        obs_addr = address_o;
        for (int i = 0; i < 4; i++) begin
            obs_beats[i] = burst_o;
            if ((wr ? write_o : read_o) !== 1'b1) obs_req_ok = 1'b0;
            for (int g = 0; g < gaps[i]; g++) begin
                resp_i = 1'b0;
                burst_i = {$urandom, $urandom};
                address_i = $urandom;
                line_i = rand256();
                tick();
                if (wr && burst_o !== obs_beats[i]) obs_hold_ok = 1'b0;
                if ((wr ? write_o : read_o) !== 1'b1) obs_req_ok = 1'b0;
            end
            resp_i = 1'b1;
            burst_i = beats[i];
            tick();
        end
        resp_i = 1'b0;
        obs_req_after = wr ? write_o : read_o;
        read_i = 1'b0;
        write_i = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        all_outs = {read_o, write_o, resp_o, burst_o, address_o, line_o};
        checks++;
        if (all_outs !== {355{1'b0}}) begin
            errors++; $display("FAIL reset_outputs got %h want 0", all_outs);
        end
        @(negedge clk);
        rst = 1'b0;
        obs_resp_cnt = 0; obs_saw_read = 1'b0; obs_saw_write = 1'b0;
        repeat (2) tick();
        checks++;
        if ({obs_resp_cnt != 0, obs_saw_read, obs_saw_write} !== 3'b000) begin
            errors++; $display("FAIL reset_idle got resp=%0d rd=%0d wr=%0d want 0 0 0",
                               obs_resp_cnt, obs_saw_read, obs_saw_write);
        end
        last_read_line = '0;
    endtask

    task automatic test_read_basic();
        beats[0] = {4{16'h1111}}; beats[1] = {4{16'h2222}};
        beats[2] = {4{16'h3333}}; beats[3] = {4{16'h4444}};
        for (int i = 0; i < 4; i++) gaps[i] = 0;
        drive_txn(1'b0, 1'b0, 32'h0000_1234, '0);
        basic_lat = obs_first_resp;
        checks++;
        if (obs_addr !== 32'h0000_1220) begin
            errors++; $display("FAIL rd_addr got %h want %h", obs_addr, 32'h0000_1220);
        end
        checks++;
        if ({obs_req_ok, obs_req_after} !== 2'b10) begin
            errors++; $display("FAIL rd_read_o got ok=%0d after=%0d want 1 0", obs_req_ok, obs_req_after);
        end
        checks++;
        if (obs_resp_cnt !== 1 || obs_first_resp !== model_latency()) begin
            errors++; $display("FAIL rd_resp got cnt=%0d at=%0d want 1 at %0d",
                               obs_resp_cnt, obs_first_resp, model_latency());
        end
        checks++;
        if (line_o !== model_line()) begin
            errors++; $display("FAIL rd_line got %h want %h", line_o, model_line());
        end
        last_read_line = model_line();
    endtask

    task automatic test_read_gaps();
        gaps[1] = 2;
        drive_txn(1'b0, 1'b0, 32'h0000_1234, '0);
        checks++;
        if (line_o !== model_line()) begin
            errors++; $display("FAIL gap_line got %h want %h", line_o, model_line());
        end
        checks++;
        if (obs_first_resp !== basic_lat + 2 || obs_resp_cnt !== 1) begin
            errors++; $display("FAIL gap_resp got cnt=%0d at=%0d want 1 at %0d",
                               obs_resp_cnt, obs_first_resp, basic_lat + 2);
        end
        checks++;
        if (obs_req_ok !== 1'b1) begin
            errors++; $display("FAIL gap_read_o got %0d want 1", obs_req_ok);
        end
        last_read_line = model_line();
    endtask

    task automatic test_write();
        logic [255:0] wl;
        wl = {64'hfedcba9876543210, 64'h0123456789abcdef, 64'h8899aabbccddeeff, 64'h0011223344556677};
        for (int i = 0; i < 4; i++) gaps[i] = 1;
        drive_txn(1'b1, 1'b0, 32'h8000_00ff, wl);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_beats[i] !== wl[64*i +: 64]) begin
                errors++; $display("FAIL wr_beat%0d got %h want %h", i, obs_beats[i], wl[64*i +: 64]);
            end
        end
        checks++;
        if ({obs_hold_ok, obs_req_ok, obs_req_after, obs_saw_read} !== 4'b1100) begin
            errors++; $display("FAIL wr_ctrl got hold=%0d ok=%0d after=%0d rd=%0d want 1 1 0 0",
                               obs_hold_ok, obs_req_ok, obs_req_after, obs_saw_read);
        end
        checks++;
        if (obs_resp_cnt !== 1 || obs_first_resp !== model_latency()) begin
            errors++; $display("FAIL wr_resp got cnt=%0d at=%0d want 1 at %0d",
                               obs_resp_cnt, obs_first_resp, model_latency());
        end
        checks++;
        if (obs_addr !== model_addr(32'h8000_00ff)) begin
            errors++; $display("FAIL wr_addr got %h want %h", obs_addr, model_addr(32'h8000_00ff));
        end
        checks++;
        if (line_o !== last_read_line) begin
            errors++; $display("FAIL wr_keeps_line got %h want %h", line_o, last_read_line);
        end
    endtask

    task automatic test_priority();
        logic [255:0] wl;
        wl = rand256();
        rand_beats(1);
        drive_txn(1'b1, 1'b1, $urandom, wl);
        checks++;
        if ({obs_saw_read, obs_saw_write} !== 2'b01) begin
            errors++; $display("FAIL prio_req got rd=%0d wr=%0d want 0 1", obs_saw_read, obs_saw_write);
        end
        checks++;
        if (obs_beats[3] !== wl[255:192] || obs_beats[0] !== wl[63:0] || obs_resp_cnt !== 1) begin
            errors++; $display("FAIL prio_data got b0=%h b3=%h cnt=%0d want %h %h 1",
                               obs_beats[0], obs_beats[3], obs_resp_cnt, wl[63:0], wl[255:192]);
        end
    endtask

    task automatic test_reset_mid_read();
        rand_beats(0);
        address_i = 32'h0000_5678; read_i = 1'b1;
        cyc = 0; obs_resp_cnt = 0;
        tick();
        resp_i = 1'b1; burst_i = beats[0]; tick();
        burst_i = beats[1]; tick();
        resp_i = 1'b0; read_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        all_outs = {read_o, write_o, resp_o, burst_o, address_o, line_o};
        checks++;
        if (all_outs !== {355{1'b0}}) begin
            errors++; $display("FAIL midrst_outputs got %h want 0", all_outs);
        end
        @(negedge clk);
        rst = 1'b0;
        obs_resp_cnt = 0; obs_saw_read = 1'b0;
        repeat (4) tick();
        checks++;
        if (obs_resp_cnt !== 0 || obs_saw_read !== 1'b0) begin
            errors++; $display("FAIL midrst_quiet got resp=%0d rd=%0d want 0 0", obs_resp_cnt, obs_saw_read);
        end
        rand_beats(0);
        drive_txn(1'b0, 1'b0, 32'h0000_9abc, '0);
        checks++;
        if (line_o !== model_line() || obs_resp_cnt !== 1 || obs_first_resp !== model_latency()) begin
            errors++; $display("FAIL midrst_reread got %h cnt=%0d at=%0d want %h 1 at %0d",
                               line_o, obs_resp_cnt, obs_first_resp, model_line(), model_latency());
        end
        last_read_line = model_line();
    endtask

    task automatic test_spurious_resp();
        obs_resp_cnt = 0; obs_saw_read = 1'b0; obs_saw_write = 1'b0;
        resp_i = 1'b1;
        repeat (3) begin
            burst_i = {$urandom, $urandom};
            tick();
        end
        resp_i = 1'b0;
        checks++;
        if ({obs_resp_cnt != 0, obs_saw_read, obs_saw_write} !== 3'b000) begin
            errors++; $display("FAIL spur_idle got resp=%0d rd=%0d wr=%0d want 0 0 0",
                               obs_resp_cnt, obs_saw_read, obs_saw_write);
        end
        rand_beats(2);
        drive_txn(1'b0, 1'b0, $urandom, '0);
        checks++;
        if (line_o[63:0] !== beats[0] || line_o !== model_line()) begin
            errors++; $display("FAIL spur_line got %h want %h", line_o, model_line());
        end
        last_read_line = model_line();
    endtask

    task automatic run_random(input int n, input int max_gap, input string tag);
        bit           wr;
        logic [31:0]  a;
        logic [255:0] wl;
        for (int t = 0; t < n; t++) begin
            wr = 1'($urandom_range(0, 1));
            a = $urandom;
            wl = rand256();
            rand_beats(max_gap);
            drive_txn(wr, 1'b0, a, wl);
            checks++;
            if (obs_addr !== model_addr(a) || obs_resp_cnt !== 1 || obs_first_resp !== model_latency()) begin
                errors++; $display("FAIL %s%0d_ctrl got addr=%h cnt=%0d at=%0d want %h 1 at %0d",
                                   tag, t, obs_addr, obs_resp_cnt, obs_first_resp, model_addr(a), model_latency());
            end
            if (wr) begin
                checks++;
                if ({obs_beats[3], obs_beats[2], obs_beats[1], obs_beats[0]} !== wl || line_o !== last_read_line) begin
                    errors++; $display("FAIL %s%0d_wr got beats=%h%h%h%h want %h",
                                       tag, t, obs_beats[3], obs_beats[2], obs_beats[1], obs_beats[0], wl);
                end
            end else begin
                checks++;
                if (line_o !== model_line()) begin
                    errors++; $display("FAIL %s%0d_rd got %h want %h", tag, t, line_o, model_line());
                end
                last_read_line = model_line();
            end
        end
    endtask

    task automatic test_back_to_back();
        run_random(4, 0, "b2b");
    endtask

    task automatic test_random();
        run_random(10, 3, "rnd");
    endtask

    initial begin
        rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        line_i = '0; address_i = '0; burst_i = '0;
        test_reset();
        test_read_basic();
        test_read_gaps();
        test_write();
        test_priority();
        test_reset_mid_read();
        test_spurious_resp();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
